// File: rtl/serial_alu_gen.sv
// Bit-serial ALU: LSB-first, NSHIFT bits per advancing cycle over 1..MAX_BYTES bytes; flags commit atomically at op end.
// Define SERIAL_ALU_SHIFT_EN to build RCL/SHL (ops 10/11); otherwise ops 10-15 are NOPs that pass arg1 through.
module serial_alu_gen #(
    parameter int  NSHIFT    = 2,
    parameter int  MAX_BYTES = 4,
    localparam int LB        = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
    localparam int CPB       = 8 / NSHIFT,
    localparam int CW        = LB + $clog2(CPB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [LB-1:0]     len_m1_i,
    input  logic [LB-1:0]     arg2_len_m1_i,
    input  logic              sext2_i,
    input  logic              update_flags_i,
    input  logic              advance_i,
    input  logic [NSHIFT-1:0] data_in1_i,
    input  logic [NSHIFT-1:0] data_in2_i,
    output logic              busy_o,
    output logic              active_o,
    output logic [NSHIFT-1:0] data_out_o,
    output logic              result_we_o,
    output logic              op_done_o,
    output logic [CW-1:0]     chunk_o,
    output logic              flag_c_o,
    output logic              flag_v_o,
    output logic              flag_s_o,
    output logic              flag_z_o
);
    localparam int MSB = NSHIFT - 1;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3,
                           OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_MOV = 4'd7,
                           OP_CMP = 4'd8, OP_NEG = 4'd9, OP_RCL = 4'd10, OP_SHL = 4'd11;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [LB-1:0]   len_q, len_d, a2len_q, a2len_d;
    logic            sext_q, sext_d, upd_q, upd_d;
    logic [CW-1:0]   chunk_q, chunk_d;
    logic            carry_q, carry_d, sign2_q, sign2_d, zrun_q, zrun_d;
    logic            fc_q, fc_d, fv_q, fv_d, fs_q, fs_d, fz_q, fz_d;
`ifdef SERIAL_ALU_SHIFT_EN
    logic            prev_q, prev_d;
    logic [NSHIFT:0] sh_cat;
`endif

    logic              busy, active, first, last, ext;
    logic              is_arith, is_logic, is_shift, is_nop, inv, cin;
    logic              c_fin, v_fin, zero_run, sign2_now;
    logic [LB-1:0]     byte_idx;
    logic [CW-1:0]     last_idx;
    logic [NSHIFT-1:0] a1, a2, b, res;
    logic [NSHIFT:0]   sum;

    assign busy     = (state_q == S_RUN);
    assign active   = busy && advance_i;
    assign first    = (chunk_q == '0);
    assign last_idx = CW'((int'(len_q) + 1) * CPB - 1);
    assign last     = (chunk_q == last_idx);
    assign byte_idx = LB'(chunk_q >> $clog2(CPB));
    // Bytes beyond arg2's valid length replicate the remembered sign (or zero).
    assign ext       = (byte_idx > a2len_q);
    assign sign2_now = ext ? sign2_q : data_in2_i[MSB];
    assign a2        = ext ? {NSHIFT{sext_q & sign2_q}} : data_in2_i;
    assign a1        = (op_q == OP_NEG) ? '0 : data_in1_i;

    assign is_arith = (op_q inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP, OP_NEG});
    assign is_logic = (op_q inside {OP_AND, OP_OR, OP_XOR, OP_MOV});
`ifdef SERIAL_ALU_SHIFT_EN
    assign is_shift = (op_q inside {OP_RCL, OP_SHL});
`else
    assign is_shift = 1'b0;
`endif
    assign is_nop   = !(is_arith || is_logic || is_shift);
    assign inv      = (op_q inside {OP_SUB, OP_SBC, OP_CMP, OP_NEG});
    assign b        = a2 ^ {NSHIFT{inv}};

    always_comb begin
        cin = carry_q;
        if (first) begin
            case (op_q)
                OP_SUB, OP_CMP, OP_NEG: cin = 1'b1;
                OP_ADC, OP_SBC:         cin = fc_q;
                default:                cin = 1'b0;
            endcase
        end
    end

    assign sum = {1'b0, a1} + {1'b0, b} + {{NSHIFT{1'b0}}, cin};

    always_comb begin
        res   = a1;
        c_fin = 1'b0;
        v_fin = 1'b0;
`ifdef SERIAL_ALU_SHIFT_EN
        sh_cat = {a1, (first ? ((op_q == OP_RCL) && fc_q) : prev_q)};
`endif
        if (is_arith) begin
            res   = sum[NSHIFT-1:0];
            c_fin = sum[NSHIFT];
            v_fin = (a1[MSB] == b[MSB]) && (res[MSB] != a1[MSB]);
        end else if (is_logic) begin
            case (op_q)
                OP_AND:  res = a1 & a2;
                OP_OR:   res = a1 | a2;
                OP_XOR:  res = a1 ^ a2;
                default: res = a2;
            endcase
        end
`ifdef SERIAL_ALU_SHIFT_EN
        else if (is_shift) begin
            res   = sh_cat[NSHIFT-1:0];
            c_fin = a1[MSB];
        end
`endif
    end

    assign zero_run = (first ? 1'b1 : zrun_q) & (res == '0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        a2len_d = a2len_q;
        sext_d  = sext_q;
        upd_d   = upd_q;
        chunk_d = chunk_q;
        carry_d = carry_q;
        sign2_d = sign2_q;
        zrun_d  = zrun_q;
        fc_d    = fc_q;
        fv_d    = fv_q;
        fs_d    = fs_q;
        fz_d    = fz_q;
`ifdef SERIAL_ALU_SHIFT_EN
        prev_d  = prev_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    op_d    = op_i;
                    len_d   = len_m1_i;
                    a2len_d = (arg2_len_m1_i > len_m1_i) ? len_m1_i : arg2_len_m1_i;
                    sext_d  = sext2_i;
                    upd_d   = update_flags_i;
                    chunk_d = '0;
                    carry_d = 1'b0;
                    sign2_d = 1'b0;
                    zrun_d  = 1'b1;
                end
            end
            default: begin
                if (advance_i) begin
                    chunk_d = chunk_q + 1'b1;
                    carry_d = sum[NSHIFT];
                    sign2_d = sign2_now;
                    zrun_d  = zero_run;
`ifdef SERIAL_ALU_SHIFT_EN
                    prev_d  = a1[MSB];
`endif
                    if (last) begin
                        state_d = S_IDLE;
                        chunk_d = '0;
                        if (upd_q && !is_nop) begin
                            fc_d = c_fin;
                            fv_d = v_fin;
                            fs_d = res[MSB];
                            fz_d = zero_run;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            a2len_q <= '0;
            sext_q  <= 1'b0;
            upd_q   <= 1'b0;
            chunk_q <= '0;
            carry_q <= 1'b0;
            sign2_q <= 1'b0;
            zrun_q  <= 1'b0;
            fc_q    <= 1'b0;
            fv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fz_q    <= 1'b0;
`ifdef SERIAL_ALU_SHIFT_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            a2len_q <= a2len_d;
            sext_q  <= sext_d;
            upd_q   <= upd_d;
            chunk_q <= chunk_d;
            carry_q <= carry_d;
            sign2_q <= sign2_d;
            zrun_q  <= zrun_d;
            fc_q    <= fc_d;
            fv_q    <= fv_d;
            fs_q    <= fs_d;
            fz_q    <= fz_d;
`ifdef SERIAL_ALU_SHIFT_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign busy_o      = busy;
    assign active_o    = active;
    assign data_out_o  = res;
    assign result_we_o = busy && (op_q != OP_CMP) && !is_nop;
    assign op_done_o   = active && last;
    assign chunk_o     = chunk_q;
    assign flag_c_o    = fc_q;
    assign flag_v_o    = fv_q;
    assign flag_s_o    = fs_q;
    assign flag_z_o    = fz_q;
endmodule

// File: tb/tb_serial_alu_gen.sv
// Scoreboard bench for serial_alu_gen (NSHIFT=2, MAX_BYTES=4): whole-word reference model, results compared at op end.
module tb_serial_alu_gen;
    localparam int NSHIFT = 2;
    localparam int MAX_BYTES = 4;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sext2 = 1'b0, upd = 1'b0, advance = 1'b0;
    logic [3:0] op = 4'd0;
    logic [1:0] len_m1 = 2'd0, a2len_m1 = 2'd0, d1 = 2'd0, d2 = 2'd0;
    logic       busy, active, result_we, op_done, fc, fv, fs, fz;
    logic [1:0] dout;
    logic [3:0] chunk;

    serial_alu_gen #(.NSHIFT(NSHIFT), .MAX_BYTES(MAX_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .len_m1_i(len_m1),
        .arg2_len_m1_i(a2len_m1), .sext2_i(sext2), .update_flags_i(upd), .advance_i(advance),
        .data_in1_i(d1), .data_in2_i(d2), .busy_o(busy), .active_o(active), .data_out_o(dout),
        .result_we_o(result_we), .op_done_o(op_done), .chunk_o(chunk),
        .flag_c_o(fc), .flag_v_o(fv), .flag_s_o(fs), .flag_z_o(fz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        we;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0, n_pass = 0;
    logic [3:0] mflags = 4'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    function automatic exp_t model(input logic [3:0] o, input int len, input int a2len, input logic sx,
                                   input logic u, input logic [31:0] a1, input logic [31:0] a2,
                                   input logic [3:0] fin);
        exp_t e;
        int nb, vb;
        logic [63:0] mask, vmask, a2e, x, y, full, res;
        logic c, v, nop;
        nb    = (len + 1) * 8;
        vb    = ((a2len > len ? len : a2len) + 1) * 8;
        mask  = (64'd1 << nb) - 1;
        vmask = (64'd1 << vb) - 1;
        a2e   = {32'd0, a2} & vmask;
        if (sx && a2e[vb-1]) a2e = a2e | (mask & ~vmask);
        x = {32'd0, a1} & mask;
        y = a2e;
        c = 1'b0; v = 1'b0; nop = 1'b0; res = x;
        case (o)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9: begin
                if (o == 4'd9) x = 64'd0;
                if (o inside {4'd1, 4'd3, 4'd8, 4'd9}) y = ~a2e & mask;
                full = x + y + ((o inside {4'd2, 4'd3}) ? {63'd0, fin[3]}
                              : (o inside {4'd1, 4'd8, 4'd9}) ? 64'd1 : 64'd0);
                res  = full & mask;
                c    = full[nb];
                v    = (x[nb-1] == y[nb-1]) && (res[nb-1] != x[nb-1]);
            end
            4'd4: res = x & a2e;
            4'd5: res = x | a2e;
            4'd6: res = x ^ a2e;
            4'd7: res = a2e;
`ifdef SERIAL_ALU_SHIFT_EN
            4'd10, 4'd11: begin
                res = ((x << 1) | ((o == 4'd10) ? {63'd0, fin[3]} : 64'd0)) & mask;
                c   = x[nb-1];
            end
`endif
            default: nop = 1'b1;
        endcase
        e.res   = res[31:0];
        e.flags = (u && !nop) ? {c, v, res[nb-1], res == 64'd0} : fin;
        e.we    = !(nop || o == 4'd8);
        return e;
    endfunction

    task automatic do_op(input logic [3:0] o, input int len, input int a2len, input logic sx, input logic u,
                         input logic [31:0] a1, input logic [31:0] a2, input int stall_at, input int stall_n);
        exp_t e;
        logic [31:0] got;
        int nch, k, done_at, cyc, stall_left;
        logic we_seen;
        e = model(o, len, a2len, sx, u, a1, a2, mflags);
        exp_q.push_back(e);
        mflags = e.flags;
        @(negedge clk);
        start = 1'b1; op = o; len_m1 = 2'(len); a2len_m1 = 2'(a2len); sext2 = sx; upd = u;
        @(negedge clk);
        start = 1'b0;
        nch = (len + 1) * 4; k = 0; done_at = -1; cyc = 0; stall_left = stall_n; got = 32'd0; we_seen = 1'b0;
        while (k < nch && cyc < 200) begin
            if (k == stall_at && stall_left > 0) begin
                // A start during a stall must be ignored while busy.
                advance = 1'b0; start = 1'b1; op = 4'd4; stall_left--;
                #1;
                check("stall_chunk", 64'(chunk), 64'(k));
                check("stall_active", 64'(active), 64'd0);
            end else begin
                start = 1'b0; op = o; advance = 1'b1; d1 = a1[2*k +: 2]; d2 = a2[2*k +: 2];
                #1;
                got[2*k +: 2] = dout;
                we_seen = result_we;
                if (op_done && done_at < 0) done_at = k + 1;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        advance = 1'b0; start = 1'b0;
        if (cyc >= 200) check("timeout", 64'(k), 64'(nch));
        #1;
        e = exp_q.pop_front();
        check("result", 64'(got), 64'(e.res));
        check("flags_cvsz", 64'({fc, fv, fs, fz}), 64'(e.flags));
        check("result_we", 64'(we_seen), 64'(e.we));
        check("op_done_at", 64'(done_at), 64'(nch));
        check("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_chunk", 64'(chunk), 64'd0);
        check("rst_flags", 64'({fc, fv, fs, fz}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'd0, 1, 1, 1'b0, 1'b1, 32'h12FF, 32'h0001, -1, 0);
        do_op(4'd0, 1, 1, 1'b0, 1'b1, 32'h12FF, 32'h0001, 2, 3);
        do_op(4'd0, 3, 0, 1'b0, 1'b1, 32'h10, 32'hA5A5A5F0, -1, 0);
        do_op(4'd0, 3, 0, 1'b1, 1'b1, 32'h10, 32'hA5A5A5F0, -1, 0);

        // Abort a 32-bit ADD mid-stream with an async reset.
        @(negedge clk);
        start = 1'b1; op = 4'd0; len_m1 = 2'd3; a2len_m1 = 2'd3; sext2 = 1'b0; upd = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            advance = 1'b1; d1 = 2'(k); d2 = 2'd3;
            @(negedge clk);
        end
        advance = 1'b0;
        #1;
        check("pre_rst_chunk", 64'(chunk), 64'd5);
        check("pre_rst_flags", 64'({fc, fv, fs, fz}), 64'(mflags));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_flags", 64'({fc, fv, fs, fz}), 64'd0);
        check("mid_rst_chunk", 64'(chunk), 64'd0);
        mflags = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'd0, 0, 0, 1'b0, 1'b1, 32'h01, 32'h01, -1, 0);
        do_op(4'd0, 0, 2, 1'b1, 1'b1, 32'h7F, 32'h01, -1, 0);
        do_op(4'd1, 0, 0, 1'b0, 1'b1, 32'h80, 32'h01, -1, 0);
        do_op(4'd8, 0, 0, 1'b0, 1'b1, 32'h80, 32'h01, -1, 0);
        do_op(4'd10, 0, 0, 1'b0, 1'b1, 32'h81, 32'h00, -1, 0);
        do_op(4'd2, 0, 0, 1'b0, 1'b1, 32'h01, 32'h01, -1, 0);
        do_op(4'd6, 1, 1, 1'b0, 1'b0, 32'h0F0F, 32'hFF00, -1, 0);
        do_op(4'd9, 1, 1, 1'b0, 1'b1, 32'h5555, 32'h0001, -1, 0);
        do_op(4'd3, 1, 0, 1'b1, 1'b1, 32'h0100, 32'h00FF, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
